// File: rtl/blink_pkg.sv
// Shared constants and types for the blink-rate path (speed_mode_ctrl, clock_divider).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blink_pkg;

  localparam int CLK_HZ = 50_000_000;

  // Blink-rate selector encoding; clock_divider decodes the same constants.
  localparam logic [2:0] MODE_1HZ = 3'd0;
  localparam logic [2:0] MODE_2HZ = 3'd1;
  localparam logic [2:0] MODE_4HZ = 3'd2;
  localparam logic [2:0] MODE_6HZ = 3'd3;
  localparam logic [2:0] MODE_8HZ = 3'd4;
  localparam logic [2:0] MAX_MODE = MODE_8HZ;

  // Hold-to-repeat state per button.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, level debounce, press edge detect, hold-to-repeat.
// Latency: step fires DEBOUNCE_CYCLES+2 edges after the first edge that samples a clean press.
// Backpressure: none; step is a single-cycle pulse with no acknowledge.
// Ports: clk, rst (sync, active-high), btn (raw, async), step (1-cycle pulse, combinational from flops).
module btn_debounce
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 12_500_000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             db;
  logic             db_q;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  rep_state_t       state;
  rep_state_t       state_nxt;
  logic             press;

  // Synchroniser and debounce: db only follows s2 after it has differed
  // for DEBOUNCE_CYCLES consecutive samples; any bounce back restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // A release always wins over a pending repeat so no step leaks out
  // in the cycle the debounced level drops.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    step         = 1'b0;
    case (state)
      ST_IDLE: begin
        hold_cnt_nxt = '0;
        if (press) begin
          step      = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!db) begin
          state_nxt    = ST_IDLE;
          hold_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          step         = 1'b1;
          state_nxt    = ST_REPEAT;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!db) begin
          state_nxt    = ST_IDLE;
          hold_cnt_nxt = '0;
        end else if (hold_cnt == REP_LAST) begin
          step         = 1'b1;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/speed_mode_ctrl.sv
// Blink-rate selector driven by faster/slower push-buttons with hold-to-repeat.
// Latency: mode_hz updates DEBOUNCE_CYCLES+3 edges after a clean press is first sampled.
// Backpressure: none; steps at a mode limit or colliding in one cycle are dropped.
// Ports: clk, rst (sync, active-high), btn_up/btn_down (raw, async),
//        mode_hz (3-bit selector, registered), mode_changed (1-cycle pulse with each new mode_hz).
module speed_mode_ctrl
  import blink_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = CLK_HZ / 50,
  parameter int         HOLD_CYCLES     = CLK_HZ,
  parameter int         REPEAT_CYCLES   = CLK_HZ / 4,
  parameter int         CNT_W           = 26,
  parameter logic [2:0] MAX_MODE        = blink_pkg::MAX_MODE,
  parameter logic [2:0] RESET_MODE      = MODE_1HZ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] mode_hz,
  output logic       mode_changed
);

  logic up_step;
  logic down_step;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_up (
    .clk (clk),
    .rst (rst),
    .btn (btn_up),
    .step(up_step)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_down (
    .clk (clk),
    .rst (rst),
    .btn (btn_down),
    .step(down_step)
  );

  // Same-cycle up/down steps cancel; a step into a limit saturates silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_hz      <= RESET_MODE;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      if (up_step && !down_step && (mode_hz < MAX_MODE)) begin
        mode_hz      <= mode_hz + 3'd1;
        mode_changed <= 1'b1;
      end else if (down_step && !up_step && (mode_hz != 3'd0)) begin
        mode_hz      <= mode_hz - 3'd1;
        mode_changed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_speed_mode_ctrl.sv
// Directed bench for speed_mode_ctrl with short debounce/hold/repeat timings.
// Latency: n/a.
// Backpressure: n/a.
module tb_speed_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic [2:0] mode_hz;
  logic       mode_changed;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int base   = 0;

  speed_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8),
    .CNT_W          (26),
    .MAX_MODE       (3'd4),
    .RESET_MODE     (3'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .mode_hz     (mode_hz),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  // Pulse counter sampled away from the active edge.
  always @(negedge clk) begin
    if (mode_changed === 1'b1) pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic press_up();
    btn_up = 1'b1;
    tick(10);
    btn_up = 1'b0;
    tick(12);
  endtask

  task automatic press_down();
    btn_down = 1'b1;
    tick(10);
    btn_down = 1'b0;
    tick(12);
  endtask

  initial begin
    bit found;
    rst      = 1'b1;
    btn_up   = 1'b1;
    btn_down = 1'b0;

    // 1. Reset with button held, then exact latency after release.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_mode", 32'(mode_hz), 0);
      check("rst_changed", 32'(mode_changed), 0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check("lat_mode_before", 32'(mode_hz), 0);
    end
    tick(1);
    check("lat_mode_edge7", 32'(mode_hz), 1);
    check("lat_changed_edge7", 32'(mode_changed), 1);
    tick(1);
    check("lat_changed_edge8", 32'(mode_changed), 0);
    btn_up = 1'b0;
    tick(20);

    // 2. Bouncy press: one increment, 4 stable samples after the last bounce.
    do_reset();
    base = pulses;
    btn_up = 1'b1; tick(1);
    btn_up = 1'b0; tick(1);
    btn_up = 1'b1; tick(1);
    btn_up = 1'b0; tick(1);
    btn_up = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check("bounce_mode_before", 32'(mode_hz), 0);
    end
    tick(1);
    check("bounce_mode_edge7", 32'(mode_hz), 1);
    btn_up = 1'b0;
    tick(20);
    check("bounce_pulses", 32'(pulses - base), 1);

    // 3. Saturation at both ends.
    do_reset();
    base = pulses;
    for (int i = 1; i <= 6; i++) begin
      press_up();
      check("sat_up_mode", 32'(mode_hz), (i < 4) ? i : 4);
    end
    check("sat_up_pulses", 32'(pulses - base), 4);
    base = pulses;
    for (int i = 1; i <= 6; i++) begin
      press_down();
      check("sat_down_mode", 32'(mode_hz), (i < 4) ? 4 - i : 0);
    end
    check("sat_down_pulses", 32'(pulses - base), 4);

    // 4. Hold-repeat: steps at press, press+20, press+28, then release.
    do_reset();
    base = pulses;
    btn_up = 1'b1;
    tick(26);
    check("hold_mode_e26", 32'(mode_hz), 1);
    tick(1);
    check("hold_mode_e27", 32'(mode_hz), 2);
    check("hold_changed_e27", 32'(mode_changed), 1);
    tick(5);
    btn_up = 1'b0;
    tick(2);
    check("hold_mode_e34", 32'(mode_hz), 2);
    tick(1);
    check("hold_mode_e35", 32'(mode_hz), 3);
    tick(40);
    check("hold_mode_final", 32'(mode_hz), 3);
    check("hold_pulses", 32'(pulses - base), 3);

    // 5. Simultaneous presses cancel, including their repeats.
    do_reset();
    press_up();
    press_up();
    check("simul_start_mode", 32'(mode_hz), 2);
    base = pulses;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick(50);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(20);
    check("simul_mode", 32'(mode_hz), 2);
    check("simul_pulses", 32'(pulses - base), 0);

    // 6. Reset while repeating; still-held button re-presses at the floor.
    do_reset();
    for (int i = 0; i < 4; i++) press_up();
    check("rrst_start_mode", 32'(mode_hz), 4);
    base = pulses;
    btn_down = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1);
      if (mode_hz === 3'd2) found = 1'b1;
    end
    check("rrst_reached_mode2", 32'(found), 1);
    tick(3);
    check("rrst_pulses_before", 32'(pulses - base), 2);
    rst = 1'b1;
    tick(2);
    check("rrst_mode_in_rst", 32'(mode_hz), 0);
    check("rrst_changed_in_rst", 32'(mode_changed), 0);
    rst = 1'b0;
    base = pulses;
    tick(40);
    check("rrst_mode_after", 32'(mode_hz), 0);
    check("rrst_pulses_after", 32'(pulses - base), 0);
    btn_down = 1'b0;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
